alu_bist_driver: RTL
====================

// Module: alu_bist_driver
// PURPOSE
//  Built-in self-test initiator for the 4-bit ALU: drives its A/B/S inputs from an LFSR vector
//  generator, waits for the result to settle, and checks the ALU outputs against an internal
//  golden model. Counts mismatches and captures the first failing vector.
//  Sits beside the ALU and replaces a bench-driven stimulus loop; the result is readable by a host/test controller.
// PARAMETERS
//  NUM_VECTORS   64     number of (A,B,S) vectors per run, 1..65535
//  LFSR_SEED     8'hA5  8-bit LFSR seed; value 0 is replaced by 8'h01
//  SETTLE_CYCLES 1      cycles operands are held before outputs are checked, >=1
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   begin run; sampled in IDLE or DONE only
//  busy           out  1   run in progress
//  done           out  1   run finished; held until next start or reset
//  pass           out  1   done && err_count==0
//  err_count      out  8   mismatching vectors, saturates at 255
//  vec_count      out  16  vectors checked in current/last run
//  fail_valid     out  1   first-failure capture valid
//  fail_a/fail_b  out  4   operands of first failing vector
//  fail_s         out  2   op select of first failing vector
//  alu_a, alu_b   out  4   ALU operands (registered)
//  alu_s          out  2   ALU op select (registered)
//  alu_sum_add    in   4   ALU add result;  alu_carry_add in 1 carry out
//  alu_sum_sub    in   4   ALU sub result;  alu_carry_sub in 1 no-borrow flag
//  alu_greater, alu_equal, alu_less in 1 each  compare flags
//  alu_out_and    in   4   ALU bitwise AND
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0; LFSR loaded with seed.
//  - FSM: IDLE -start-> SETTLE; SETTLE -(SETTLE_CYCLES elapsed)-> CHECK;
//    CHECK -(last vector)-> DONE else SETTLE; DONE -start-> SETTLE. start ignored in SETTLE/CHECK.
//  - On a start edge: err_count, vec_count and fail_* are cleared; LFSR reloaded with seed; vector 0 is driven.
//    busy=1, done=0.
//  - Vector order: A=lfsr[7:4], B=lfsr[3:0]; S steps 00,01,10,11 on the same A,B; after S=11 the LFSR advances:
//    lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//  - alu_a/b/s update only on entry to SETTLE, held constant through CHECK.
//  - CHECK samples ALU inputs and compares only the group selected by alu_s:
//    00: {carry_add,sum_add} == A+B (5-bit)
//    01: {carry_sub,sum_sub} == A+~B+1 (5-bit; carry=1 iff A>=B unsigned)
//    10: {greater,equal,less} == unsigned compare, exactly one bit set
//    11: out_and == A&B
//  - Mismatch: err_count+1 (saturating); if fail_valid=0, capture fail_a/b/s and set fail_valid.
//  - vec_count increments every CHECK. Latency from the start edge to done=1 is NUM_VECTORS*(SETTLE_CYCLES+1) cycles.
//  - Entering DONE: busy=0, done=1; alu_a/b/s hold the last vector; counters frozen.
//  - rst_n low mid-run aborts immediately; no partial results survive.
// TESTING
//  1 Assert rst_n=0 mid-clock -> all outputs 0 without a clock edge; state IDLE.
//  2 Correct ALU model, NUM_VECTORS=8, SETTLE=1: start -> done exactly 16 cycles later; pass=1, err=0, vec_count=8;
//    vector 0: A=4'hA, B=4'h5, S=00.
//  3 Force alu_sum_add[0]=0 -> first vector (A+B=0F) fails: fail_valid=1, fail_a=A, fail_b=5, fail_s=00; pass=0.
//  4 Pulse start during busy -> ignored, timing unchanged; start again in DONE -> identical err/fail results.
//  5 Tie all ALU outputs to 0, NUM_VECTORS=300 -> err_count saturates at 255; vec_count=300.
//  6 Set LFSR_SEED=0 -> vector 0 is A=0, B=1; compare step expects less=1.

Source files
------------

// File: rtl/alu_bist_driver.sv
// Built-in self-test initiator for the 4-bit ALU.
// An LFSR generates the operands and each operand pair is applied with all four op selects.
// After the operands settle, the ALU outputs are checked against a golden model.
// The block counts mismatches and captures the first failing vector.
module alu_bist_driver #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] vec_count,
  output logic        fail_valid,
  output logic [3:0]  fail_a,
  output logic [3:0]  fail_b,
  output logic [1:0]  fail_s,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_s,
  input  logic [3:0]  alu_sum_add,
  input  logic        alu_carry_add,
  input  logic [3:0]  alu_sum_sub,
  input  logic        alu_carry_sub,
  input  logic        alu_greater,
  input  logic        alu_equal,
  input  logic        alu_less,
  input  logic [3:0]  alu_out_and
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0]  SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] VEC_LAST    = 16'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic [15:0] settle_cnt;

  logic [7:0]  lfsr_next;
  logic        mismatch;
  logic [7:0]  err_inc;
  logic [4:0]  exp_add;
  logic [4:0]  exp_sub;

  // The next vector reuses the current A,B until all four op selects are done.
  // alu_s doubles as the op-select sequencer.
  always_comb begin
    lfsr_next = lfsr;
    if (alu_s == 2'd3)
      lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Golden model: compare only the output group selected by the current op.
  always_comb begin
    exp_add  = {1'b0, alu_a} + {1'b0, alu_b};
    exp_sub  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
    mismatch = 1'b0;
    unique case (alu_s)
      2'd0: mismatch = ({alu_carry_add, alu_sum_add} != exp_add);
      2'd1: mismatch = ({alu_carry_sub, alu_sum_sub} != exp_sub);
      2'd2: mismatch = ({alu_greater, alu_equal, alu_less} !=
                        {alu_a > alu_b, alu_a == alu_b, alu_a < alu_b});
      default: mismatch = (alu_out_and != (alu_a & alu_b));
    endcase
    err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  // Control FSM with registered vector drive, counters and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_s     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            lfsr       <= SEED;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_s     <= '0;
            alu_a      <= SEED[7:4];
            alu_b      <= SEED[3:0];
            alu_s      <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= CHECK;
          else settle_cnt <= settle_cnt + 16'd1;
        end
        CHECK: begin
          vec_count <= vec_count + 16'd1;
          if (mismatch) begin
            err_count <= err_inc;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= alu_a;
              fail_b     <= alu_b;
              fail_s     <= alu_s;
            end
          end
          if (vec_count == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_count == 8'd0);
          end else begin
            state      <= SETTLE;
            settle_cnt <= '0;
            lfsr       <= lfsr_next;
            alu_a      <= lfsr_next[7:4];
            alu_b      <= lfsr_next[3:0];
            alu_s      <= alu_s + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
